mux8_tree: RTL and testbench

- Registered 8:1 multiplexer built as a three-level binary tree of 2:1 mux cells (4 → 2 → 1).
- Selects one of eight WIDTH-bit lanes packed into one input bus, using a 3-bit select.
- Presents the selected lane on a registered output with a valid flag.
- Used as a generic lane-select primitive in datapaths that need a deterministic, glitch-free registered result.

---
 rtl/mux8_tree_pkg.sv | 14 +
 rtl/mux8_tree_mux2_cell.sv | 21 ++
 rtl/mux8_tree.sv | 146 ++++++++++++++
 tb/tb_mux8_tree.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/mux8_tree_pkg.sv
// Shared constants for the mux8_tree lane-select primitive.
// PIPE_DEPTH follows the MUX8_TREE_PIPE_EN build option (3 register stages when defined).
package mux8_tree_pkg;

    localparam int NUM_LANES = 8;
    localparam int SEL_W     = 3;

`ifdef MUX8_TREE_PIPE_EN
    localparam int PIPE_DEPTH = 3;
`else
    localparam int PIPE_DEPTH = 1;
`endif

endpackage

// File: rtl/mux8_tree_mux2_cell.sv
// Combinational 2:1 cell used at every level of the mux8_tree select tree.
// Returns a (the lower-indexed input) when sel is low, b when sel is high.
module mux2_cell #(
    parameter int WIDTH = 1
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sel,
    output logic [WIDTH-1:0] y
);

    // Single 2:1 select.
    always_comb begin
        if (sel) begin
            y = b;
        end else begin
            y = a;
        end
    end

endmodule

// File: rtl/mux8_tree.sv
// Registered 8:1 lane select built as a 4-2-1 tree of mux2_cell instances.
// Build option MUX8_TREE_PIPE_EN inserts a register after each tree level (3-cycle latency).
module mux8_tree
    import mux8_tree_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_LANES*WIDTH-1:0] i,
    input  logic [SEL_W-1:0]           s,
    input  logic                       in_valid,
    output logic [WIDTH-1:0]           o,
    output logic                       out_valid
);

    logic [WIDTH-1:0] l0_y [4];
    logic [WIDTH-1:0] l1_a [4];
    logic             l1_sel;
    logic [WIDTH-1:0] l1_y [2];
    logic [WIDTH-1:0] l2_a [2];
    logic             l2_sel;
    logic [WIDTH-1:0] l2_y;
    logic             cap_valid;

    logic [WIDTH-1:0] o_d;
    logic [WIDTH-1:0] o_q;
    logic             out_valid_d;
    logic             out_valid_q;

    for (genvar c = 0; c < 4; c++) begin : g_l0
        mux2_cell #(.WIDTH(WIDTH)) u_cell (
            .a   (i[(2*c)*WIDTH +: WIDTH]),
            .b   (i[(2*c+1)*WIDTH +: WIDTH]),
            .sel (s[0]),
            .y   (l0_y[c])
        );
    end

`ifdef MUX8_TREE_PIPE_EN
    // Each stage carries its data together with the select bits still needed downstream.
    logic [WIDTH-1:0] st0_d  [4];
    logic [WIDTH-1:0] st0_q  [4];
    logic [1:0]       sel0_d;
    logic [1:0]       sel0_q;
    logic             vld0_d;
    logic             vld0_q;
    logic [WIDTH-1:0] st1_d  [2];
    logic [WIDTH-1:0] st1_q  [2];
    logic             sel1_d;
    logic             sel1_q;
    logic             vld1_d;
    logic             vld1_q;

    // Next-state for the two intermediate pipeline stages.
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            st0_d[k] = l0_y[k];
        end
        sel0_d = s[2:1];
        vld0_d = in_valid;
        for (int k = 0; k < 2; k++) begin
            st1_d[k] = l1_y[k];
        end
        sel1_d = sel0_q[1];
        vld1_d = vld0_q;
    end

    // Intermediate stage registers; reset flushes in-flight results.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < 4; k++) begin
                st0_q[k] <= {WIDTH{1'b0}};
            end
            sel0_q <= 2'b00;
            vld0_q <= 1'b0;
            for (int k = 0; k < 2; k++) begin
                st1_q[k] <= {WIDTH{1'b0}};
            end
            sel1_q <= 1'b0;
            vld1_q <= 1'b0;
        end else begin
            st0_q  <= st0_d;
            sel0_q <= sel0_d;
            vld0_q <= vld0_d;
            st1_q  <= st1_d;
            sel1_q <= sel1_d;
            vld1_q <= vld1_d;
        end
    end

    assign l1_a      = st0_q;
    assign l1_sel    = sel0_q[0];
    assign l2_a      = st1_q;
    assign l2_sel    = sel1_q;
    assign cap_valid = vld1_q;
`else
    assign l1_a      = l0_y;
    assign l1_sel    = s[1];
    assign l2_a      = l1_y;
    assign l2_sel    = s[2];
    assign cap_valid = in_valid;
`endif

    for (genvar c = 0; c < 2; c++) begin : g_l1
        mux2_cell #(.WIDTH(WIDTH)) u_cell (
            .a   (l1_a[2*c]),
            .b   (l1_a[2*c+1]),
            .sel (l1_sel),
            .y   (l1_y[c])
        );
    end

    mux2_cell #(.WIDTH(WIDTH)) u_l2_cell (
        .a   (l2_a[0]),
        .b   (l2_a[1]),
        .sel (l2_sel),
        .y   (l2_y)
    );

    // Output capture: take the tree result on a valid slot, otherwise hold the last value.
    always_comb begin
        if (cap_valid) begin
            o_d         = l2_y;
            out_valid_d = 1'b1;
        end else begin
            o_d         = o_q;
            out_valid_d = 1'b0;
        end
    end

    // Output register with synchronous reset overriding capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            o_q         <= {WIDTH{1'b0}};
            out_valid_q <= 1'b0;
        end else begin
            o_q         <= o_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign o         = o_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_mux8_tree.sv
// Self-checking bench for mux8_tree: WIDTH=1 and WIDTH=8 instances against a queue-based latency model.
// Latency follows MUX8_TREE_PIPE_EN (1 cycle default, 3 when defined).
module tb_mux8_tree;

`ifdef MUX8_TREE_PIPE_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 1;
`endif

    typedef struct {
        logic [2:0]  s;
        logic        exp1;
        logic [7:0]  exp8;
    } vec_t;

    typedef struct {
        bit          v;
        logic [63:0] d1;
        logic [63:0] d8;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  i1;
    logic [63:0] i8;
    logic [2:0]  s;
    logic        v;
    logic        o1;
    logic        ov1;
    logic [7:0]  o8;
    logic        ov8;

    int          n_tests = 0;
    int          n_fail  = 0;
    ent_t        q[$];
    logic [63:0] mo1;
    logic [63:0] mo8;
    logic        mov;
    vec_t        tbl[16];

    always #5 clk = ~clk;

    mux8_tree #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst), .i(i1), .s(s), .in_valid(v), .o(o1), .out_valid(ov1)
    );

    mux8_tree #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .i(i8), .s(s), .in_valid(v), .o(o8), .out_valid(ov8)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: o is lane[s] taken LAT edges after sampling; reset empties the pipe.
    task automatic model_edge();
        ent_t e;
        ent_t f;
        if (rst) begin
            q.delete();
            for (int k = 0; k < LAT - 1; k++) begin
                e.v = 1'b0; e.d1 = 64'd0; e.d8 = 64'd0;
                q.push_back(e);
            end
            mo1 = 64'd0;
            mo8 = 64'd0;
            mov = 1'b0;
        end else begin
            e.v  = v;
            e.d1 = (64'(i1) >> s) & 64'h1;
            e.d8 = (i8 >> (8 * s)) & 64'hFF;
            q.push_back(e);
            f   = q.pop_front();
            mov = f.v;
            if (f.v) begin
                mo1 = f.d1;
                mo8 = f.d8;
            end
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        chk("model_o1", 64'(o1), mo1);
        chk("model_ov1", 64'(ov1), 64'(mov));
        chk("model_o8", 64'(o8), mo8);
        chk("model_ov8", 64'(ov8), 64'(mov));
    endtask

    initial begin
        logic sweep_bits [8];
        sweep_bits = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        for (int k = 0; k < 8; k++) begin
            tbl[k].s        = 3'(k);
            tbl[k].exp1     = sweep_bits[k];
            tbl[k].exp8     = 8'(8'h10 + k);
            tbl[8 + k].s    = 3'(7 - k);
            tbl[8 + k].exp1 = sweep_bits[7 - k];
            tbl[8 + k].exp8 = 8'(8'h17 - k);
        end

        rst = 1'b1; v = 1'b1; s = 3'd0; i1 = 8'hB5; i8 = 64'h1716151413121110;
        for (int k = 0; k < 2; k++) begin
            cycle();
            chk("rst_o1", 64'(o1), 64'd0);
            chk("rst_ov1", 64'(ov1), 64'd0);
            chk("rst_o8", 64'(o8), 64'd0);
        end

        // First capture after release: s=2 on 8'hB5 selects 1, lane 2 of i8 is 8'h12.
        rst = 1'b0; s = 3'd2;
        for (int k = 0; k < LAT; k++) cycle();
        chk("first_o1", 64'(o1), 64'd1);
        chk("first_o8", 64'(o8), 64'h12);
        chk("first_ov", 64'(ov1), 64'd1);

        i1 = 8'b10110101;
        for (int k = 0; k < 16 + LAT - 1; k++) begin
            if (k < 16) begin
                v = 1'b1; s = tbl[k].s;
            end else begin
                v = 1'b0;
            end
            cycle();
            if (k >= LAT - 1) begin
                chk("sweep_o1", 64'(o1), 64'(tbl[k - (LAT - 1)].exp1));
                chk("sweep_o8", 64'(o8), 64'(tbl[k - (LAT - 1)].exp8));
                chk("sweep_ov", 64'(ov1), 64'd1);
            end
        end

        v = 1'b1; s = 3'b101; i1 = 8'b10110101;
        cycle();
        v = 1'b0; s = 3'd0; i1 = 8'h00;
        for (int k = 0; k < LAT + 1; k++) cycle();
        chk("hold_o1", 64'(o1), 64'd1);
        chk("hold_o8", 64'(o8), 64'h15);
        chk("hold_ov", 64'(ov1), 64'd0);

        // Mid-stream reset discards everything in flight.
        for (int k = 0; k < 4; k++) begin
            v = 1'b1; s = 3'($urandom_range(7)); i1 = 8'($urandom); i8 = {$urandom, $urandom};
            cycle();
        end
        rst = 1'b1;
        cycle();
        chk("midrst_ov", 64'(ov1), 64'd0);
        chk("midrst_o8", 64'(o8), 64'd0);
        rst = 1'b0; v = 1'b0;
        for (int k = 0; k < LAT + 1; k++) begin
            cycle();
            chk("flush_ov", 64'(ov8), 64'd0);
        end

        for (int k = 0; k < 300; k++) begin
            rst = ($urandom_range(19) == 0);
            v   = 1'($urandom);
            s   = 3'($urandom_range(7));
            i1  = 8'($urandom);
            i8  = {$urandom, $urandom};
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
